// File: rtl/cpu7_ifu_imd_pkg.sv
// cpu7_ifu_imd_pkg: shared constants and state encoding for the instruction-memory driver
package cpu7_ifu_imd_pkg;
  localparam int IMD_MAX_OUT = 2;
  localparam int IMD_CNT_W = 2;
  localparam logic [5:0] ECODE_ADEF = 6'h08;
  typedef enum logic [1:0] {IMD_IDLE, IMD_ADDR, IMD_DATA} imd_state_e;
endpackage

// File: rtl/cpu7_ifu_imd_if.sv
// cpu7_ifu_imd_if: fetch-side and instruction-bus signals of the instruction-memory driver
interface cpu7_ifu_imd_if;
  logic         ifu_inst_req;
  logic [31:0]  ifu_inst_addr;
  logic         ifu_inst_cancel;
  logic         inst_addr_ok;
  logic         inst_valid;
  logic [127:0] inst_rdata;
  logic [1:0]   inst_count;
  logic         inst_ex;
  logic [5:0]   inst_exccode;
  logic         inst_uncache;
  logic         bus_req;
  logic [31:0]  bus_addr;
  logic         bus_addr_ok;
  logic         bus_data_ok;
  logic [31:0]  bus_rdata;
  modport master (
    input  ifu_inst_req, ifu_inst_addr, ifu_inst_cancel, bus_addr_ok, bus_data_ok, bus_rdata,
    output inst_addr_ok, inst_valid, inst_rdata, inst_count, inst_ex, inst_exccode, inst_uncache,
           bus_req, bus_addr
  );
  modport slave (
    output ifu_inst_req, ifu_inst_addr, ifu_inst_cancel, bus_addr_ok, bus_data_ok, bus_rdata,
    input  inst_addr_ok, inst_valid, inst_rdata, inst_count, inst_ex, inst_exccode, inst_uncache,
           bus_req, bus_addr
  );
endinterface

// File: rtl/cpu7_ifu_imd.sv
// cpu7_ifu_imd: turns fdp level fetch requests into one in-order bus transaction per address,
// dropping responses of cancelled fetches.
module cpu7_ifu_imd
  import cpu7_ifu_imd_pkg::*;
#(
  parameter int MAX_OUT = IMD_MAX_OUT,
  parameter int CNT_W = IMD_CNT_W
) (
  input logic clock,
  input logic resetn,
  cpu7_ifu_imd_if.master imd
);
  imd_state_e r_state, w_state_nxt;
  logic [CNT_W-1:0] r_out_cnt, r_drop_cnt;
  logic [31:0] r_addr_q;
  logic r_kill;
  logic w_fetch, w_misalign, w_issue, w_acc, w_killed, w_drop_hit, w_own_data, w_drop_inc;
  assign w_fetch = r_state == IMD_IDLE && imd.ifu_inst_req && !imd.ifu_inst_cancel;
  assign w_misalign = w_fetch && imd.ifu_inst_addr[1:0] != 2'b00;
  assign w_issue = w_fetch && imd.ifu_inst_addr[1:0] == 2'b00 && r_out_cnt < CNT_W'(MAX_OUT);
  assign w_acc = imd.bus_req && imd.bus_addr_ok;
  // a cancel seen at any point while waiting for addr_ok still kills that fetch
  assign w_killed = r_kill || imd.ifu_inst_cancel;
  assign w_drop_hit = imd.bus_data_ok && r_drop_cnt != '0;
  assign w_own_data = r_state == IMD_DATA && imd.bus_data_ok && r_drop_cnt == '0;
  assign w_drop_inc = (r_state == IMD_ADDR && w_acc && w_killed) ||
                      (r_state == IMD_DATA && imd.ifu_inst_cancel && !w_own_data);
  assign imd.bus_req = w_issue || r_state == IMD_ADDR;
  assign imd.bus_addr = r_state == IMD_IDLE ? imd.ifu_inst_addr : r_addr_q;
  assign imd.inst_addr_ok = w_acc && !w_killed;
  assign imd.inst_valid = (w_own_data && !imd.ifu_inst_cancel) || w_misalign;
  assign imd.inst_rdata = {96'b0, w_misalign ? 32'b0 : imd.bus_rdata};
  assign imd.inst_count = 2'd1;
  assign imd.inst_ex = w_misalign;
  assign imd.inst_exccode = w_misalign ? ECODE_ADEF : 6'h0;
  assign imd.inst_uncache = 1'b0;
  always_comb begin
    w_state_nxt = r_state;
    if (w_issue) w_state_nxt = imd.bus_addr_ok ? IMD_DATA : IMD_ADDR;
    else if (r_state == IMD_ADDR && imd.bus_addr_ok) w_state_nxt = w_killed ? IMD_IDLE : IMD_DATA;
    else if (r_state == IMD_DATA && (imd.ifu_inst_cancel || w_own_data)) w_state_nxt = IMD_IDLE;
  end
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= IMD_IDLE;
      r_out_cnt <= '0;
      r_drop_cnt <= '0;
      r_addr_q <= '0;
      r_kill <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_out_cnt <= r_out_cnt + CNT_W'(w_acc) - CNT_W'(imd.bus_data_ok);
      r_drop_cnt <= r_drop_cnt + CNT_W'(w_drop_inc) - CNT_W'(w_drop_hit);
      r_addr_q <= w_issue ? imd.ifu_inst_addr : r_addr_q;
      r_kill <= r_state == IMD_ADDR && !imd.bus_addr_ok && w_killed;
    end
  end
  always_ff @(posedge clock) begin
    if (resetn) assert (!imd.bus_data_ok || r_out_cnt != '0);
  end
endmodule

// File: tb/tb_cpu7_ifu_imd.sv
// tb_cpu7_ifu_imd: directed fetch scenarios against a small in-order bus model; a monitor
// pops the expected-instruction queue on every inst_valid.
module tb_cpu7_ifu_imd;
  import cpu7_ifu_imd_pkg::*;
  typedef struct packed {logic [31:0] w; logic ex;} exp_t;
  typedef struct {logic [31:0] w; int rdy;} pend_t;
  logic clock = 1'b0, resetn = 1'b0;
  int checks = 0, failures = 0;
  exp_t exp_q[$];
  logic [31:0] rd_q[$];
  pend_t pend_q[$];
  int addr_wait = 0, data_wait = 1, wcnt = 0, cyc = 0, acc_cnt = 0, a0 = 0;
  logic b_acc, b_dok, b_wait;
  logic [31:0] b_word;
  logic prev_hold = 1'b0;
  logic [31:0] prev_addr = '0;
  exp_t e;
  cpu7_ifu_imd_if imd_if();
  cpu7_ifu_imd dut (.clock(clock), .resetn(resetn), .imd(imd_if));
  always #5 clock = ~clock;
  assign imd_if.bus_addr_ok = imd_if.bus_req && wcnt >= addr_wait;
  function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endfunction
  task automatic tick;
    @(posedge clock);
    #2;
  endtask
  task automatic fetch(input logic [31:0] a, input logic [31:0] w, input int lat);
    int n = 0;
    exp_q.push_back('{w, 1'b0});
    rd_q.push_back(w);
    imd_if.ifu_inst_req = 1'b1;
    imd_if.ifu_inst_addr = a;
    forever begin
      @(negedge clock);
      if (imd_if.inst_valid || n == 30) break;
      tick();
      n++;
    end
    if (!imd_if.inst_valid) begin
      checks++;
      failures++;
      $display("FAIL fetch_timeout addr=%0h actual=no inst_valid required=inst_valid", a);
    end else chk("latency", 128'(n), 128'(lat));
    tick();
    imd_if.ifu_inst_req = 1'b0;
  endtask
  initial begin
    imd_if.bus_data_ok = 1'b0;
    imd_if.bus_rdata = '0;
    forever begin
      @(posedge clock);
      b_acc = imd_if.bus_req && imd_if.bus_addr_ok;
      b_dok = imd_if.bus_data_ok;
      b_wait = imd_if.bus_req && !imd_if.bus_addr_ok;
      #1;
      cyc++;
      if (!resetn) begin
        pend_q.delete();
        wcnt = 0;
      end else begin
        if (b_dok) void'(pend_q.pop_front());
        if (b_acc) begin
          acc_cnt++;
          b_word = rd_q.size() > 0 ? rd_q.pop_front() : 32'h0;
          pend_q.push_back('{b_word, cyc - 1 + data_wait});
        end
        wcnt = b_acc ? 0 : wcnt + int'(b_wait);
      end
      imd_if.bus_data_ok = pend_q.size() > 0 && pend_q[0].rdy <= cyc;
      imd_if.bus_rdata = imd_if.bus_data_ok ? pend_q[0].w : 32'h0;
    end
  end
  initial forever begin
    @(negedge clock);
    if (!resetn) prev_hold = 1'b0;
    else begin
      if (prev_hold) begin
        chk("hold_req", 128'(imd_if.bus_req), 128'(1));
        chk("hold_addr", 128'(imd_if.bus_addr), 128'(prev_addr));
      end
      prev_hold = imd_if.bus_req && !imd_if.bus_addr_ok;
      prev_addr = imd_if.bus_addr;
      if (imd_if.inst_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_valid actual rdata=%0h required=no inst_valid", imd_if.inst_rdata);
        end else begin
          e = exp_q.pop_front();
          chk("rdata", imd_if.inst_rdata, {96'b0, e.w});
          chk("ex", 128'(imd_if.inst_ex), 128'(e.ex));
          chk("exccode", 128'(imd_if.inst_exccode), 128'(e.ex ? ECODE_ADEF : 6'h0));
        end
      end
    end
  end
  initial begin
    imd_if.ifu_inst_req = 1'b0;
    imd_if.ifu_inst_addr = '0;
    imd_if.ifu_inst_cancel = 1'b0;
    tick();
    tick();
    chk("rst_bus_req", 128'(imd_if.bus_req), 128'(0));
    chk("rst_valid", 128'(imd_if.inst_valid), 128'(0));
    chk("rst_addr_ok", 128'(imd_if.inst_addr_ok), 128'(0));
    chk("rst_ex", 128'(imd_if.inst_ex), 128'(0));
    chk("inst_count", 128'(imd_if.inst_count), 128'(1));
    chk("inst_uncache", 128'(imd_if.inst_uncache), 128'(0));
    resetn = 1'b1;
    tick();
    // zero-wait bus, back-to-back fetches
    a0 = acc_cnt;
    fetch(32'h1c000000, 32'he3ff0000, 1);
    fetch(32'h1c000004, 32'he3ff0004, 1);
    chk("t1_transactions", 128'(acc_cnt - a0), 128'(2));
    // addr_ok three cycles late
    addr_wait = 3;
    a0 = acc_cnt;
    fetch(32'h1c000008, 32'he3ff0008, 4);
    chk("t2_transactions", 128'(acc_cnt - a0), 128'(1));
    addr_wait = 0;
    // cancel while waiting for data, then redirect
    data_wait = 3;
    a0 = acc_cnt;
    rd_q.push_back(32'hdeadbeef);
    imd_if.ifu_inst_req = 1'b1;
    imd_if.ifu_inst_addr = 32'h1c000010;
    tick();
    imd_if.ifu_inst_req = 1'b0;
    imd_if.ifu_inst_cancel = 1'b1;
    tick();
    imd_if.ifu_inst_cancel = 1'b0;
    fetch(32'h1c000100, 32'he3ff0100, 3);
    chk("t3_transactions", 128'(acc_cnt - a0), 128'(2));
    data_wait = 1;
    // cancel while the address is still pending
    addr_wait = 3;
    a0 = acc_cnt;
    rd_q.push_back(32'h11111111);
    imd_if.ifu_inst_req = 1'b1;
    imd_if.ifu_inst_addr = 32'h1c000020;
    tick();
    imd_if.ifu_inst_req = 1'b0;
    imd_if.ifu_inst_cancel = 1'b1;
    tick();
    imd_if.ifu_inst_cancel = 1'b0;
    tick();
    chk("t4_bus_req", 128'(imd_if.bus_req), 128'(1));
    chk("t4_bus_addr", 128'(imd_if.bus_addr), 128'(32'h1c000020));
    chk("t4_addr_ok_out", 128'(imd_if.inst_addr_ok), 128'(0));
    tick();
    tick();
    tick();
    chk("t4_transactions", 128'(acc_cnt - a0), 128'(1));
    addr_wait = 0;
    fetch(32'h1c000024, 32'he3ff0024, 1);
    // cancel in the same cycle as own data_ok
    data_wait = 2;
    rd_q.push_back(32'h22222222);
    imd_if.ifu_inst_req = 1'b1;
    imd_if.ifu_inst_addr = 32'h1c000028;
    tick();
    imd_if.ifu_inst_req = 1'b0;
    tick();
    imd_if.ifu_inst_cancel = 1'b1;
    #1;
    chk("t5_data_ok", 128'(imd_if.bus_data_ok), 128'(1));
    chk("t5_valid", 128'(imd_if.inst_valid), 128'(0));
    tick();
    imd_if.ifu_inst_cancel = 1'b0;
    data_wait = 1;
    fetch(32'h1c000030, 32'he3ff0030, 1);
    // misaligned fetch address
    exp_q.push_back('{32'h0, 1'b1});
    imd_if.ifu_inst_req = 1'b1;
    imd_if.ifu_inst_addr = 32'h1c000002;
    #1;
    chk("t6_bus_req", 128'(imd_if.bus_req), 128'(0));
    chk("t6_valid", 128'(imd_if.inst_valid), 128'(1));
    tick();
    imd_if.ifu_inst_req = 1'b0;
    tick();
    // async reset with a drop and two transactions outstanding
    data_wait = 5;
    rd_q.push_back(32'h33333333);
    rd_q.push_back(32'h44444444);
    imd_if.ifu_inst_req = 1'b1;
    imd_if.ifu_inst_addr = 32'h1c000040;
    tick();
    imd_if.ifu_inst_req = 1'b0;
    imd_if.ifu_inst_cancel = 1'b1;
    tick();
    imd_if.ifu_inst_cancel = 1'b0;
    imd_if.ifu_inst_req = 1'b1;
    imd_if.ifu_inst_addr = 32'h1c000044;
    tick();
    imd_if.ifu_inst_req = 1'b0;
    #1;
    resetn = 1'b0;
    #1;
    chk("arst_bus_req", 128'(imd_if.bus_req), 128'(0));
    chk("arst_valid", 128'(imd_if.inst_valid), 128'(0));
    chk("arst_addr_ok", 128'(imd_if.inst_addr_ok), 128'(0));
    chk("arst_ex", 128'(imd_if.inst_ex), 128'(0));
    tick();
    resetn = 1'b1;
    data_wait = 1;
    tick();
    fetch(32'h1c000050, 32'he3ff0050, 1);
    tick();
    tick();
    chk("exp_queue_empty", 128'(exp_q.size()), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
